// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of a single 8-bit adder (Adder_8)
// among NUM_REQ requesters. One op per grant. The operands are registered,
// added, and the result is returned on a ready/valid response port.
// Optional per-requester grant counters are built when ADDER_ARB_STATS_EN is defined.

// Adder_8: 8-bit adder with an 8-bit carry-in operand (only bit 0 is ever nonzero here)
module Adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {1'b0, cin};
endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_cin,
  output logic [NUM_REQ-1:0]   req_gnt,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_sum,
  output logic                 rsp_cout,
  input  logic                 rsp_ready,
  output logic                 busy
`ifdef ADDER_ARB_STATS_EN
  , output logic [NUM_REQ*16-1:0] stat_grants
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, k;
  logic            found, gnt_en;
  logic [7:0]      sel_a, sel_b;
  logic            sel_cin;
  logic [7:0]      op_a, op_b;
  logic            op_cin;
  logic [ID_W-1:0] op_id;
  logic [7:0]      add_sum;
  logic            add_cout;

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall
  always_comb begin
    found = 1'b0;
    k     = '0;
    for (int j = NUM_REQ-1; j >= 0; j--)
      if (req_valid[j]) begin
        k     = ID_W'(j);
        found = 1'b1;
      end
    for (int j = NUM_REQ-1; j >= 0; j--)
      if (req_valid[j] && ID_W'(j) >= ptr) k = ID_W'(j);
  end

  // A grant can go out from IDLE, or from RESP in the cycle the response is taken
  assign gnt_en = rst_n && found &&
                  ((state == IDLE) || (state == RESP && rsp_ready));

  // One-hot grant and operand mux; only the granted slice is looked at
  always_comb begin
    req_gnt = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int j = 0; j < NUM_REQ; j++)
      if (k == ID_W'(j)) begin
        req_gnt[j] = gnt_en;
        sel_a      = req_a[8*j +: 8];
        sel_b      = req_b[8*j +: 8];
        sel_cin    = req_cin[j];
      end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_en) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = gnt_en ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  Adder_8 u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  ({7'b0, op_cin}),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operand capture on grant, result capture in EXEC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      op_id    <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else begin
      if (gnt_en) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_cin <= sel_cin;
        op_id  <= k;
        ptr    <= (k == ID_W'(NUM_REQ-1)) ? '0 : k + ID_W'(1);
      end
      if (state == EXEC) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_id   <= op_id;
      end
    end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef ADDER_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    // Saturating grant counter for requester g
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                              cnt[g] <= '0;
      else if (req_gnt[g] && cnt[g] != 16'hFFFF) cnt[g] <= cnt[g] + 16'd1;
  end

  assign stat_grants = cnt;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (NUM_REQ=4). Inputs change 1ns after
// posedge; outputs are checked 1ns later, well away from the next edge.
module tb_adder_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_cin, req_gnt;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_cout, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
`ifdef ADDER_ARB_STATS_EN
  logic [63:0] stat_grants;
`endif

  int errors = 0;
  int checks = 0;

  adder_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ready(rsp_ready), .busy(busy)
`ifdef ADDER_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; req_cin = 4'h0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #3;
    chk("rst_gnt", req_gnt, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_cout", rsp_cout, 0);
    tick(); tick();
    rst_n = 1'b1; req_valid = 4'h0;
    #1;

    // Single op from requester 0, noise on the other slices
    req_valid = 4'b0001; req_a = 32'h5555_5501; req_b = 32'h3333_3301; req_cin = 4'b1110;
    #1;
    chk("t1_gnt", req_gnt, 4'b0001);
    chk("t1_idle_busy", busy, 0);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t1_exec_gnt", req_gnt, 0);
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_valid", rsp_valid, 0);
    tick();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_sum", rsp_sum, 8'h02);
    chk("t1_cout", rsp_cout, 0);
    chk("t1_id", rsp_id, 0);
    tick();
    chk("t1_done_valid", rsp_valid, 0);
    chk("t1_done_busy", busy, 0);

    // Overflow from requester 2
    req_valid = 4'b0100; req_a = 32'h12FF_3456; req_b = 32'h9901_7788; req_cin = 4'b0100;
    #1;
    chk("ovf_gnt", req_gnt, 4'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("ovf_sum", rsp_sum, 8'h01);
    chk("ovf_cout", rsp_cout, 1);
    chk("ovf_id", rsp_id, 2);
    tick();

    // Asynchronous reset pulse brings ptr back to 0
    rst_n = 1'b0; #1; rst_n = 1'b1;

    // Round-robin with every requester valid and rsp_ready high
    req_a = {8'd40, 8'd30, 8'd20, 8'd10};
    req_b = {8'd4, 8'd3, 8'd2, 8'd1};
    req_cin = 4'h0; req_valid = 4'hF; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c % 2 == 0) begin
        chk("rr_gnt", req_gnt, 64'(4'b0001 << ((c / 2) % 4)));
        if (c >= 2) begin
          chk("rr_id", rsp_id, 64'((c / 2 - 1) % 4));
          chk("rr_sum", rsp_sum, 64'(11 * ((c / 2 - 1) % 4 + 1)));
        end
      end else begin
        chk("rr_gnt_gap", req_gnt, 0);
      end
      tick();
    end

    // Now in RESP holding requester 0's result; stall for 5 cycles
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_sum, 8'd11);
      chk("bp_id", rsp_id, 0);
      chk("bp_cout", rsp_cout, 0);
      chk("bp_gnt", req_gnt, 0);
      chk("bp_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_gnt", req_gnt, 4'b0010);
    tick();

    // Reset while in EXEC
    rst_n = 1'b0;
    #1;
    chk("rx_valid", rsp_valid, 0);
    chk("rx_busy", busy, 0);
    chk("rx_gnt", req_gnt, 0);
    rst_n = 1'b1;
    #1;
    chk("rx_first_gnt", req_gnt, 4'b0001);
    tick();

    // Requesters 1 and 2 drop out before being granted: scan from ptr=1 lands on 3
    req_valid = 4'b1001;
    tick();
    chk("skip_id", rsp_id, 0);
    chk("skip_sum", rsp_sum, 8'd11);
    chk("skip_gnt", req_gnt, 4'b1000);
    tick();
    // ptr wraps to 0; requester 0 is idle so requester 1 wins
    req_valid = 4'b0110;
    tick();
    chk("wrap_id", rsp_id, 3);
    chk("wrap_sum", rsp_sum, 8'd44);
    chk("wrap_gnt", req_gnt, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("wrap2_id", rsp_id, 1);
    chk("wrap2_sum", rsp_sum, 8'd22);
    tick();
    chk("end_busy", busy, 0);

`ifdef ADDER_ARB_STATS_EN
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req_valid = 4'b0010;
    tick(); tick(); tick(); tick(); tick();
    req_valid = 4'b0000;
    #1;
    chk("stat_grants", stat_grants, {16'd0, 16'd0, 16'd3, 16'd0});
    tick(); tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
